// File: rtl/proc_frame_serializer_pkg.sv
// Shared constants and FSM encoding for the frame serializer and its ping-pong buffer.
// Imported by the RTL and by the testbench.
package proc_frame_serializer_pkg;

    localparam int          DEF_DATA_W    = 704;
    localparam int          DEF_WORD_W    = 32;
    localparam logic [15:0] DEF_HDR_MAGIC = 16'hA55A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } ser_state_t;

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-slot frame store. Frames are drained in arrival order. A capture arriving
// while both slots are full is dropped and counted.
module frame_pingpong_buf
    import proc_frame_serializer_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int WORD_W    = DEF_WORD_W,
    localparam int NUM_WORDS = DATA_W / WORD_W,
    localparam int IDX_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              rel,
    input  logic [IDX_W-1:0]  word_idx,
    output logic              cap_accept,
    output logic              rd_full,
    output logic              other_full,
    output logic              any_full,
    output logic [WORD_W-1:0] rd_word,
    output logic [15:0]       drop_cnt
);

    logic [1:0]        full_reg;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [15:0]       drop_reg;
    logic [DATA_W-1:0] slot_mem [2];
    logic [DATA_W-1:0] rd_slot;
    logic [WORD_W-1:0] rd_words [NUM_WORDS];
    logic [IDX_W-1:0]  sel;

    // The slot being released this cycle still reads as full here, so a
    // coincident capture can never land on data that is still draining.
    assign cap_accept = capture & ~full_reg[wr_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg   <= 2'b00;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            drop_reg   <= 16'd0;
        end else begin
            if (cap_accept) begin
                full_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end else if (capture && drop_reg != 16'hFFFF) begin
                drop_reg <= drop_reg + 16'd1;
            end
            if (rel) begin
                full_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg           <= ~rd_ptr_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_accept) begin
            slot_mem[wr_ptr_reg] <= cap_data;
        end
    end

    assign rd_slot = slot_mem[rd_ptr_reg];

    // Word 0 is the most significant word of the frame.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign rd_words[gi] = rd_slot[(NUM_WORDS-1-gi)*WORD_W +: WORD_W];
        end
    endgenerate

    assign sel        = (word_idx < IDX_W'(NUM_WORDS)) ? word_idx : '0;
    assign rd_word    = rd_words[sel];
    assign rd_full    = full_reg[rd_ptr_reg];
    assign other_full = full_reg[~rd_ptr_reg];
    assign any_full   = |full_reg;
    assign drop_cnt   = drop_reg;

endmodule

// File: rtl/proc_frame_serializer.sv
// Streams each captured frame as header, payload words (MSB first) and an XOR
// checksum over a valid/ready interface.
module proc_frame_serializer
    import proc_frame_serializer_pkg::*;
#(
    parameter  int          DATA_W    = DEF_DATA_W,
    parameter  int          WORD_W    = DEF_WORD_W,
    parameter  logic [15:0] HDR_MAGIC = DEF_HDR_MAGIC,
    localparam int          NUM_WORDS = DATA_W / WORD_W,
    localparam int          IDX_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       drop_cnt
);

    ser_state_t        state_reg;
    logic              in_valid_d_reg;
    logic [15:0]       seq_reg;
    logic [WORD_W-1:0] csum_reg;
    logic [IDX_W-1:0]  idx_reg;

    logic              capture;
    logic              rel;
    logic              cap_accept;
    logic              rd_full;
    logic              other_full;
    logic              any_full;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] hdr_word;

    assign capture  = in_valid & ~in_valid_d_reg;
    assign rel      = (state_reg == ST_CSUM) & out_ready;
    assign hdr_word = {HDR_MAGIC, seq_reg};
    assign busy     = any_full | (state_reg != ST_IDLE);

    frame_pingpong_buf #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .cap_data   (in_data),
        .rel        (rel),
        .word_idx   (idx_reg),
        .cap_accept (cap_accept),
        .rd_full    (rd_full),
        .other_full (other_full),
        .any_full   (any_full),
        .rd_word    (rd_word),
        .drop_cnt   (drop_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_d_reg <= 1'b0;
        end else begin
            in_valid_d_reg <= in_valid;
        end
    end

    // idx_reg names the payload word to load on the next handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            seq_reg   <= 16'd0;
            csum_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rd_full) begin
                        state_reg <= ST_HDR;
                        out_valid <= 1'b1;
                        out_data  <= hdr_word;
                        out_last  <= 1'b0;
                        idx_reg   <= '0;
                    end
                end
                ST_HDR: begin
                    if (out_ready) begin
                        csum_reg  <= out_data;
                        seq_reg   <= seq_reg + 16'd1;
                        out_data  <= rd_word;
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (out_ready) begin
                        csum_reg <= csum_reg ^ out_data;
                        if (idx_reg == IDX_W'(NUM_WORDS)) begin
                            out_data  <= csum_reg ^ out_data;
                            out_last  <= 1'b1;
                            state_reg <= ST_CSUM;
                        end else begin
                            out_data <= rd_word;
                            idx_reg  <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (out_ready) begin
                        out_last <= 1'b0;
                        // Next frame already stored or landing this cycle: no bubble.
                        if (other_full || cap_accept) begin
                            state_reg <= ST_HDR;
                            out_data  <= hdr_word;
                            idx_reg   <= '0;
                        end else begin
                            state_reg <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_frame_serializer.sv
// Self-checking bench: a frame-level scoreboard checks every accepted word, drop
// count and busy, plus literal expectations for the directed scenarios.
module tb_proc_frame_serializer;
    import proc_frame_serializer_pkg::*;

    localparam int DW = 704;
    localparam int WW = 32;
    localparam int NW = DW / WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic [15:0]   drop_cnt;

    proc_frame_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int ready_mode = 0;   // 0: low, 1: high, 2: random

    exp_t        exp_q[$];
    int          m_pending = 0;
    int          m_drop = 0;
    logic [15:0] m_seq = 16'd0;
    logic        m_prev_in = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: looks at the settled state just before each rising edge.
    always @(negedge clk) begin
        logic ev;
        logic hs;
        logic [31:0] x;
        logic [31:0] w;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            chk("reset_busy", 32'(busy), 32'd0);
            exp_q.delete();
            m_pending = 0;
            m_drop = 0;
            m_seq = 16'd0;
            m_prev_in = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("busy", 32'(busy), 32'(m_pending != 0));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            ev = in_valid & ~m_prev_in;
            hs = out_valid & out_ready;
            if (ev) begin
                if (m_pending < 2) begin
                    x = {16'hA55A, m_seq};
                    e.d = x; e.l = 1'b0; exp_q.push_back(e);
                    for (int i = 0; i < NW; i++) begin
                        w = in_data[(NW-1-i)*WW +: WW];
                        x = x ^ w;
                        e.d = w; e.l = 1'b0; exp_q.push_back(e);
                    end
                    e.d = x; e.l = 1'b1; exp_q.push_back(e);
                    m_seq = m_seq + 16'd1;
                    m_pending++;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (hs) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                got_c.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_data, 32'hDEADBEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", out_data, e.d);
                    chk("last", 32'(out_last), 32'(e.l));
                    if (e.l) m_pending--;
                end
            end
            m_prev_in  = in_valid;
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic send_frame(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k = 0;
        while (got_d.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(got_d.size()), 32'(n));
    endtask

    function automatic logic [DW-1:0] ramp(input logic [31:0] base);
        logic [DW-1:0] d;
        for (int i = 0; i < NW; i++) d[(NW-1-i)*WW +: WW] = base + 32'(i + 1);
        return d;
    endfunction

    initial begin
        logic [DW-1:0] d;
        int k;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // One frame, ready always high: latency, throughput, literal words.
        ready_mode = 1;
        clear_log();
        in_valid = 1'b1;
        in_data  = ramp(32'd0);
        @(negedge clk);
        chk("lat_n0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(out_valid), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_words(24, 200, "t1_count");
        if (got_d.size() >= 24) begin
            chk("t1_hdr", got_d[0], 32'hA55A0000);
            chk("t1_w1", got_d[1], 32'h00000001);
            chk("t1_w22", got_d[22], 32'h00000016);
            chk("t1_csum", got_d[23], 32'hA55A0017);
            chk("t1_last", 32'(got_l[23]), 32'd1);
            chk("t1_nolast", 32'(got_l[22]), 32'd0);
            chk("t1_burst", 32'(got_c[23] - got_c[0]), 32'd23);
        end
        repeat (4) tick();

        // Random backpressure on a ramp frame.
        ready_mode = 2;
        clear_log();
        send_frame(ramp(32'd0));
        wait_words(24, 400, "t2_count");
        if (got_d.size() >= 24) begin
            chk("t2_hdr", got_d[0], 32'hA55A0001);
            chk("t2_csum", got_d[23], 32'hA55A0016);
        end
        repeat (4) tick();

        // Three frames while stalled: third is dropped.
        ready_mode = 0;
        clear_log();
        send_frame(ramp(32'h100));
        send_frame(ramp(32'h200));
        send_frame(ramp(32'h300));
        tick();
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        chk("t3_busy", 32'(busy), 32'd1);
        ready_mode = 1;
        wait_words(48, 300, "t3_count");
        repeat (30) tick();
        chk("t3_total", 32'(got_d.size()), 32'd48);
        if (got_d.size() >= 48) begin
            chk("t3_hdr_a", got_d[0], 32'hA55A0002);
            chk("t3_hdr_b", got_d[24], 32'hA55A0003);
            chk("t3_b_w1", got_d[25], 32'h00000201);
        end

        // in_valid held high: exactly one frame.
        clear_log();
        in_valid = 1'b1;
        in_data  = ramp(32'h400);
        repeat (100) tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("t4_total", 32'(got_d.size()), 32'd24);
        if (got_d.size() >= 1) chk("t4_hdr", got_d[0], 32'hA55A0004);

        // Capture on the exact checksum-handshake cycle.
        clear_log();
        send_frame(ramp(32'h500));
        k = 0;
        while (!(out_valid && out_last) && k < 100) begin
            tick();
            k++;
        end
        in_valid = 1'b1;
        in_data  = ramp(32'hB000_0000);
        tick();
        in_valid = 1'b0;
        wait_words(48, 200, "t5_count");
        if (got_d.size() >= 48) begin
            chk("t5_gap", 32'(got_c[24] - got_c[23]), 32'd1);
            chk("t5_hdr_b", got_d[24], 32'hA55A0006);
            chk("t5_b_w1", got_d[25], 32'hB0000001);
            chk("t5_a_w22", got_d[22], 32'h00000516);
        end
        repeat (4) tick();

        // Reset in the middle of a frame.
        clear_log();
        send_frame(ramp(32'h600));
        k = 0;
        while (got_d.size() < 10 && k < 100) begin
            tick();
            k++;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_drop", 32'(drop_cnt), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        send_frame(ramp(32'h700));
        wait_words(24, 200, "t6_count");
        if (got_d.size() >= 1) chk("t6_hdr", got_d[0], 32'hA55A0000);
        repeat (4) tick();

        // Randomized frames and gaps under random backpressure.
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NW; i++) d[i*WW +: WW] = $urandom;
            send_frame(d);
            repeat ($urandom_range(0, 40)) tick();
        end
        ready_mode = 1;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 2000) begin
            tick();
            k++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
